// File: rtl/sha3_axil_frontend.sv
// AXI4-Lite register front-end for the SHA3 core.
// Message words written to DATA are queued in a small FIFO and streamed to the
// core over valid/ready. The final word carries a byte count armed through CTRL.
// The 256-bit digest is captured on core_out_valid and read back one word per
// DIGEST read.
module sha3_axil_frontend #(
  parameter int DW         = 32,
  parameter int AW         = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            s00_axi_aclk,
  input  logic            s00_axi_areset,
  input  logic [AW-1:0]   s00_axi_awaddr,
  input  logic [2:0]      s00_axi_awprot,
  input  logic            s00_axi_awvalid,
  output logic            s00_axi_awready,
  input  logic [DW-1:0]   s00_axi_wdata,
  input  logic [DW/8-1:0] s00_axi_wstrb,
  input  logic            s00_axi_wvalid,
  output logic            s00_axi_wready,
  output logic [1:0]      s00_axi_bresp,
  output logic            s00_axi_bvalid,
  input  logic            s00_axi_bready,
  input  logic [AW-1:0]   s00_axi_araddr,
  input  logic [2:0]      s00_axi_arprot,
  input  logic            s00_axi_arvalid,
  output logic            s00_axi_arready,
  output logic [DW-1:0]   s00_axi_rdata,
  output logic [1:0]      s00_axi_rresp,
  output logic            s00_axi_rvalid,
  input  logic            s00_axi_rready,
  output logic            core_init,
  output logic [31:0]     core_in_data,
  output logic            core_in_last,
  output logic [1:0]      core_in_bytes,
  output logic            core_in_valid,
  input  logic            core_in_ready,
  input  logic [255:0]    core_out_digest,
  input  logic            core_out_valid
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_DATA    = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [1:0] REG_DIGEST  = 2'd3;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [DW+2:0]  fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic [DW+2:0]  head;
  logic [2:0]     count3;
  logic           empty, full;

  logic           last_armed, busy, digest_valid;
  logic [1:0]     last_bytes;
  logic [2:0]     idx;
  logic [255:0]   digest_q;

  logic [1:0]     wr_sel, rd_sel;
  logic           wr_fire, rd_fire, ctrl_wr, data_wr, init, push, pop, digest_rd;
  logic [DW-1:0]  status, rd_word;
  logic [1:0]     rd_resp;
  logic           unused_ok;

  assign unused_ok = ^{s00_axi_awprot, s00_axi_wstrb, s00_axi_arprot,
                       s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  assign wr_sel    = s00_axi_awaddr[3:2];
  assign rd_sel    = s00_axi_araddr[3:2];
  assign wr_fire   = s00_axi_awready && s00_axi_awvalid && s00_axi_wvalid;
  assign rd_fire   = s00_axi_arready && s00_axi_arvalid;
  assign ctrl_wr   = wr_fire && (wr_sel == REG_CTRL);
  assign data_wr   = wr_fire && (wr_sel == REG_DATA);
  assign init      = ctrl_wr && s00_axi_wdata[0];
  assign push      = data_wr && !full;
  assign pop       = core_in_valid && core_in_ready;
  assign digest_rd = rd_fire && (rd_sel == REG_DIGEST) && digest_valid;

  assign empty  = (count == '0);
  assign full   = (count == CW'(FIFO_DEPTH));
  assign count3 = 3'(count);
  assign status = {{(DW-7){1'b0}}, count3, busy, digest_valid, full, empty};

  assign head          = fifo_mem[rd_ptr];
  assign core_in_data  = head[DW+2:3];
  assign core_in_last  = head[2];
  assign core_in_bytes = head[1:0];
  assign core_in_valid = !empty;

  // Read data mux; STATUS/DIGEST sample state as it stands before the accept edge
  always_comb begin
    rd_word = '0;
    rd_resp = RESP_OKAY;
    case (rd_sel)
      REG_STATUS: rd_word = status;
      REG_DIGEST: begin
        if (digest_valid) rd_word = digest_q[{idx, 5'b0} +: 32];
        else              rd_resp = RESP_SLVERR;
      end
      default: rd_word = '0;
    endcase
  end

  // Write channel: one-cycle address/data ready, then hold bvalid until bready
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      s00_axi_awready <= 1'b0;
      s00_axi_wready  <= 1'b0;
      s00_axi_bvalid  <= 1'b0;
      s00_axi_bresp   <= RESP_OKAY;
    end else begin
      if (!s00_axi_awready && !s00_axi_bvalid && s00_axi_awvalid && s00_axi_wvalid &&
          !((wr_sel == REG_DATA) && full)) begin
        s00_axi_awready <= 1'b1;
        s00_axi_wready  <= 1'b1;
      end else begin
        s00_axi_awready <= 1'b0;
        s00_axi_wready  <= 1'b0;
      end
      if (wr_fire) begin
        s00_axi_bvalid <= 1'b1;
        s00_axi_bresp  <= (wr_sel[1]) ? RESP_SLVERR : RESP_OKAY;
      end else if (s00_axi_bready) begin
        s00_axi_bvalid <= 1'b0;
      end
    end
  end

  // Read channel: one-cycle arready, registered response held until rready
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      s00_axi_arready <= 1'b0;
      s00_axi_rvalid  <= 1'b0;
      s00_axi_rdata   <= '0;
      s00_axi_rresp   <= RESP_OKAY;
    end else begin
      s00_axi_arready <= !s00_axi_arready && !s00_axi_rvalid && s00_axi_arvalid;
      if (rd_fire) begin
        s00_axi_rvalid <= 1'b1;
        s00_axi_rdata  <= rd_word;
        s00_axi_rresp  <= rd_resp;
      end else if (s00_axi_rready) begin
        s00_axi_rvalid <= 1'b0;
      end
    end
  end

  // Input word FIFO; INIT flushes it and overrides any concurrent pop
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else if (init) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {s00_axi_wdata, last_armed, (last_armed ? last_bytes : 2'b00)};
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Control state: INIT pulse, last-word arming, busy flag, digest capture and readout index
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      core_init    <= 1'b0;
      last_armed   <= 1'b0;
      last_bytes   <= 2'b00;
      busy         <= 1'b0;
      digest_valid <= 1'b0;
      idx          <= 3'd0;
      digest_q     <= '0;
    end else begin
      core_init <= init;
      if (digest_rd) idx <= idx + 3'd1;
      if (core_out_valid) begin
        digest_q     <= core_out_digest;
        digest_valid <= 1'b1;
        idx          <= 3'd0;
        busy         <= 1'b0;
      end
      if (push) begin
        last_armed <= 1'b0;
        if (last_armed) busy <= 1'b1;
      end
      if (ctrl_wr) begin
        last_armed <= s00_axi_wdata[1];
        last_bytes <= s00_axi_wdata[3:2];
        if (s00_axi_wdata[0]) begin
          digest_valid <= 1'b0;
          idx          <= 3'd0;
          busy         <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sha3_axil_frontend.sv
// Scoreboard bench for sha3_axil_frontend: drivers queue expected B/R/core
// responses, a monitor compares them when the DUT presents each handshake.
module tb_sha3_axil_frontend;

  logic         s00_axi_aclk = 1'b0;
  logic         s00_axi_areset = 1'b1;
  logic [3:0]   s00_axi_awaddr = '0;
  logic [2:0]   s00_axi_awprot = '0;
  logic         s00_axi_awvalid = 1'b0;
  logic         s00_axi_awready;
  logic [31:0]  s00_axi_wdata = '0;
  logic [3:0]   s00_axi_wstrb = 4'hF;
  logic         s00_axi_wvalid = 1'b0;
  logic         s00_axi_wready;
  logic [1:0]   s00_axi_bresp;
  logic         s00_axi_bvalid;
  logic         s00_axi_bready = 1'b0;
  logic [3:0]   s00_axi_araddr = '0;
  logic [2:0]   s00_axi_arprot = '0;
  logic         s00_axi_arvalid = 1'b0;
  logic         s00_axi_arready;
  logic [31:0]  s00_axi_rdata;
  logic [1:0]   s00_axi_rresp;
  logic         s00_axi_rvalid;
  logic         s00_axi_rready = 1'b0;
  logic         core_init;
  logic [31:0]  core_in_data;
  logic         core_in_last;
  logic [1:0]   core_in_bytes;
  logic         core_in_valid;
  logic         core_in_ready = 1'b0;
  logic [255:0] core_out_digest = '0;
  logic         core_out_valid = 1'b0;

  always #5 s00_axi_aclk = ~s00_axi_aclk;

  sha3_axil_frontend #(.DW(32), .AW(4), .FIFO_DEPTH(4)) dut (
    .s00_axi_aclk(s00_axi_aclk), .s00_axi_areset(s00_axi_areset),
    .s00_axi_awaddr(s00_axi_awaddr), .s00_axi_awprot(s00_axi_awprot),
    .s00_axi_awvalid(s00_axi_awvalid), .s00_axi_awready(s00_axi_awready),
    .s00_axi_wdata(s00_axi_wdata), .s00_axi_wstrb(s00_axi_wstrb),
    .s00_axi_wvalid(s00_axi_wvalid), .s00_axi_wready(s00_axi_wready),
    .s00_axi_bresp(s00_axi_bresp), .s00_axi_bvalid(s00_axi_bvalid),
    .s00_axi_bready(s00_axi_bready),
    .s00_axi_araddr(s00_axi_araddr), .s00_axi_arprot(s00_axi_arprot),
    .s00_axi_arvalid(s00_axi_arvalid), .s00_axi_arready(s00_axi_arready),
    .s00_axi_rdata(s00_axi_rdata), .s00_axi_rresp(s00_axi_rresp),
    .s00_axi_rvalid(s00_axi_rvalid), .s00_axi_rready(s00_axi_rready),
    .core_init(core_init), .core_in_data(core_in_data), .core_in_last(core_in_last),
    .core_in_bytes(core_in_bytes), .core_in_valid(core_in_valid),
    .core_in_ready(core_in_ready), .core_out_digest(core_out_digest),
    .core_out_valid(core_out_valid)
  );

  int checks = 0;
  int failures = 0;
  int init_hi = 0;

  logic [1:0]  b_exp [$];
  logic [33:0] r_exp [$];
  logic [34:0] c_exp [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [1:0] exp_resp);
    int n;
    b_exp.push_back(exp_resp);
    @(posedge s00_axi_aclk); #1;
    s00_axi_awaddr = addr; s00_axi_wdata = data;
    s00_axi_awvalid = 1'b1; s00_axi_wvalid = 1'b1; s00_axi_bready = 1'b1;
    n = 0;
    @(negedge s00_axi_aclk);
    while (!s00_axi_awready && n < 300) begin @(negedge s00_axi_aclk); n++; end
    if (!s00_axi_awready) begin
      checks++; failures++;
      $display("FAIL aw_timeout addr=%0h actual awready=0 required=1", addr);
    end
    @(posedge s00_axi_aclk); #1;
    s00_axi_awvalid = 1'b0; s00_axi_wvalid = 1'b0;
    n = 0;
    @(negedge s00_axi_aclk);
    while (!s00_axi_bvalid && n < 50) begin @(negedge s00_axi_aclk); n++; end
    if (!s00_axi_bvalid) begin
      checks++; failures++;
      $display("FAIL b_timeout addr=%0h actual bvalid=0 required=1", addr);
    end
    @(posedge s00_axi_aclk); #1;
    s00_axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp);
    int n;
    r_exp.push_back({exp_resp, exp_data});
    @(posedge s00_axi_aclk); #1;
    s00_axi_araddr = addr; s00_axi_arvalid = 1'b1; s00_axi_rready = 1'b1;
    n = 0;
    @(negedge s00_axi_aclk);
    while (!s00_axi_arready && n < 50) begin @(negedge s00_axi_aclk); n++; end
    if (!s00_axi_arready) begin
      checks++; failures++;
      $display("FAIL ar_timeout addr=%0h actual arready=0 required=1", addr);
    end
    @(posedge s00_axi_aclk); #1;
    s00_axi_arvalid = 1'b0;
    n = 0;
    @(negedge s00_axi_aclk);
    while (!s00_axi_rvalid && n < 50) begin @(negedge s00_axi_aclk); n++; end
    if (!s00_axi_rvalid) begin
      checks++; failures++;
      $display("FAIL r_timeout addr=%0h actual rvalid=0 required=1", addr);
    end
    @(posedge s00_axi_aclk); #1;
    s00_axi_rready = 1'b0;
  endtask

  task automatic push_data(input logic [31:0] data, input logic last, input logic [1:0] bytes);
    c_exp.push_back({data, last, bytes});
    axi_write(4'h4, data, 2'b00);
  endtask

  task automatic drain();
    int n;
    @(posedge s00_axi_aclk); #1;
    core_in_ready = 1'b1;
    n = 0;
    @(negedge s00_axi_aclk);
    while (core_in_valid && n < 50) begin @(negedge s00_axi_aclk); n++; end
    check("drain_empty", 64'(core_in_valid), 64'd0);
    @(posedge s00_axi_aclk); #1;
    core_in_ready = 1'b0;
  endtask

  initial begin
    fork
      begin : monitor
        logic [1:0]  eb;
        logic [33:0] er;
        logic [34:0] ec;
        forever begin
          @(negedge s00_axi_aclk);
          if (!s00_axi_areset) begin
            if (core_init) init_hi++;
            if (s00_axi_bvalid && s00_axi_bready) begin
              if (b_exp.size() == 0) check("b_unexpected", 64'(s00_axi_bresp), 64'hDEAD);
              else begin eb = b_exp.pop_front(); check("bresp", 64'(s00_axi_bresp), 64'(eb)); end
            end
            if (s00_axi_rvalid && s00_axi_rready) begin
              if (r_exp.size() == 0) check("r_unexpected", 64'(s00_axi_rdata), 64'hDEAD);
              else begin
                er = r_exp.pop_front();
                check("rresp_rdata", 64'({s00_axi_rresp, s00_axi_rdata}), 64'(er));
              end
            end
            if (core_in_valid && core_in_ready) begin
              if (c_exp.size() == 0) check("core_unexpected", 64'(core_in_data), 64'hDEAD);
              else begin
                ec = c_exp.pop_front();
                check("core_word", 64'({core_in_data, core_in_last, core_in_bytes}), 64'(ec));
              end
            end
          end
        end
      end
      begin : stimulus
        logic stall_ok;
        // reset: every output low
        repeat (2) @(posedge s00_axi_aclk);
        repeat (3) begin
          @(negedge s00_axi_aclk);
          check("reset_axi", 64'({s00_axi_awready, s00_axi_wready, s00_axi_bresp, s00_axi_bvalid,
                                  s00_axi_arready, s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid}), 64'd0);
          check("reset_core", 64'({core_init, core_in_data, core_in_last, core_in_bytes,
                                   core_in_valid}), 64'd0);
        end
        @(posedge s00_axi_aclk); #1;
        s00_axi_areset = 1'b0;
        axi_read(4'h8, 32'h0000_0001, 2'b00);

        // fill FIFO, then stall a fifth write until one pop
        push_data(32'h11, 1'b0, 2'd0);
        push_data(32'h22, 1'b0, 2'd0);
        push_data(32'h33, 1'b0, 2'd0);
        push_data(32'h44, 1'b0, 2'd0);
        axi_read(4'h8, 32'h0000_0042, 2'b00);
        fork
          push_data(32'h55, 1'b0, 2'd0);
          begin
            stall_ok = 1'b1;
            repeat (6) begin @(negedge s00_axi_aclk); if (s00_axi_awready) stall_ok = 1'b0; end
            check("full_stall_no_awready", 64'(stall_ok), 64'd1);
            @(posedge s00_axi_aclk); #1 core_in_ready = 1'b1;
            @(posedge s00_axi_aclk); #1 core_in_ready = 1'b0;
          end
        join
        axi_read(4'h8, 32'h0000_0042, 2'b00);
        drain();
        axi_read(4'h8, 32'h0000_0001, 2'b00);

        // last-word tagging and busy
        axi_write(4'h0, 32'h0000_000A, 2'b00);
        push_data(32'hDEAD_BEEF, 1'b1, 2'd2);
        axi_read(4'h8, 32'h0000_0018, 2'b00);
        push_data(32'hCAFE_F00D, 1'b0, 2'd0);
        axi_read(4'h8, 32'h0000_0028, 2'b00);
        drain();
        axi_read(4'h8, 32'h0000_0009, 2'b00);

        // error responses and unmapped reads
        axi_read(4'hC, 32'h0, 2'b10);
        axi_write(4'h8, 32'hFFFF_FFFF, 2'b10);
        axi_read(4'h8, 32'h0000_0009, 2'b00);
        axi_write(4'hC, 32'h1234_5678, 2'b10);
        axi_read(4'h4, 32'h0, 2'b00);
        axi_read(4'h0, 32'h0, 2'b00);

        // digest capture and wrapping readout
        for (int i = 0; i < 8; i++) core_out_digest[32*i +: 32] = 32'hA5A5_0000 + 32'(i);
        @(posedge s00_axi_aclk); #1 core_out_valid = 1'b1;
        @(posedge s00_axi_aclk); #1 core_out_valid = 1'b0;
        axi_read(4'h8, 32'h0000_0005, 2'b00);
        for (int i = 0; i < 9; i++) axi_read(4'hC, 32'hA5A5_0000 + 32'(i % 8), 2'b00);

        // INIT coinciding with a pop
        push_data(32'h100, 1'b0, 2'd0);
        push_data(32'h101, 1'b0, 2'd0);
        push_data(32'h102, 1'b0, 2'd0);
        axi_read(4'h8, 32'h0000_0034, 2'b00);
        fork
          axi_write(4'h0, 32'h0000_0001, 2'b00);
          begin
            int n;
            n = 0;
            @(negedge s00_axi_aclk);
            while (!s00_axi_awready && n < 100) begin @(negedge s00_axi_aclk); n++; end
            #1 core_in_ready = 1'b1;
            @(posedge s00_axi_aclk); #1 core_in_ready = 1'b0;
            @(negedge s00_axi_aclk);
            check("core_init_high", 64'(core_init), 64'd1);
            @(negedge s00_axi_aclk);
            check("core_init_low_after", 64'(core_init), 64'd0);
          end
        join
        c_exp.delete();
        axi_read(4'h8, 32'h0000_0001, 2'b00);
        axi_read(4'hC, 32'h0, 2'b10);
        push_data(32'h200, 1'b0, 2'd0);
        drain();
        axi_read(4'h8, 32'h0000_0001, 2'b00);

        repeat (3) @(negedge s00_axi_aclk);
        check("b_queue_empty", 64'(b_exp.size()), 64'd0);
        check("r_queue_empty", 64'(r_exp.size()), 64'd0);
        check("core_queue_empty", 64'(c_exp.size()), 64'd0);
        check("core_init_cycles", 64'(init_hi), 64'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
      begin : watchdog
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "watchdog");
      end
    join
  end

endmodule

// File: doc/sha3_axil_frontend.md
# sha3_axil_frontend

AXI4-Lite slave front-end for the SHA3 accelerator: it decodes 32-bit register writes and reads from the bus master and converts message words into a valid/ready stream for the SHA3 core. It buffers input words in a small FIFO, tags the last word with a byte count, and captures the 256-bit digest for word-by-word readout. It sits directly downstream of the AXI4-Lite bus master and directly upstream of the SHA3 permutation core.

## Interface
- `DW`, 32, AXI data width (fixed at 32)
- `AW`, 4, AXI byte-address width; registers at 0x0, 0x4, 0x8, 0xC
- `FIFO_DEPTH`, 4, input word FIFO depth (power of two)

Ports:
- `s00_axi_aclk` in 1: single clock; everything is on its rising edge
- `s00_axi_areset` in 1: synchronous, active-high reset
- `s00_axi_awaddr`/`awprot`/`awvalid` in AW/3/1: write address channel (`awprot` ignored); `s00_axi_awready` out 1
- `s00_axi_wdata`/`wstrb`/`wvalid` in DW/DW/8/1: write data channel (`wstrb` ignored); `s00_axi_wready` out 1
- `s00_axi_bresp`/`bvalid` out 2/1, `s00_axi_bready` in 1: write response channel
- `s00_axi_araddr`/`arprot`/`arvalid` in AW/3/1: read address channel (`arprot` ignored); `s00_axi_arready` out 1
- `s00_axi_rdata`/`rresp`/`rvalid` out DW/2/1, `s00_axi_rready` in 1: read data channel
- `core_init` out 1: one-cycle pulse that restarts the hash
- `core_in_data` out 32, `core_in_last` out 1, `core_in_bytes` out 2: head-of-FIFO word, last flag, valid bytes (0 means 4)
- `core_in_valid` out 1, `core_in_ready` in 1: stream handshake
- `core_out_digest` in 256, `core_out_valid` in 1: digest and its capture strobe

## Operation
- Registers, decoded from `addr[3:2]`:
  - CTRL 0x0 (W): bit0 INIT pulse; bit1 LAST_ARM; bits[3:2] LAST_BYTES.
  - DATA 0x4 (W): pushes a word into the FIFO.
  - STATUS 0x8 (R): bit0 empty, bit1 full, bit2 digest_valid, bit3 busy, bits[6:4] count, other bits 0.
  - DIGEST 0xC (R): returns `digest[32*idx +: 32]`.
- Write to CTRL with bit0 = 1:
  - flushes the FIFO, clears digest_valid, last_armed and idx;
  - pulses `core_init` for exactly one cycle.
  - Bits 1 and 3:2 are latched into last_armed and last_bytes.
- DATA push:
  - The entry is {data, last_armed, last_armed ? last_bytes : 0}.
  - last_armed clears at the same edge.
  - A push with `last_armed`=1 sets busy.
- Write decode responses:
  - writes to STATUS or DIGEST have no effect and return `bresp`=2'b10 (SLVERR);
  - all other writes return 2'b00.
- Read responses:
  - DIGEST read with digest_valid=0 returns 0 with `rresp`=2'b10 and does not advance idx;
  - otherwise `rresp`=2'b00.
  - Read of DATA or CTRL returns 0.
- Digest readout: a valid DIGEST read advances idx, which wraps 7→0.
- Core stream:
  - `core_in_valid` = !empty.
  - A pop occurs when `core_in_valid` && `core_in_ready`.
- Digest capture: when `core_out_valid` is high, the digest is captured, digest_valid=1, idx=0, busy=0.
- Simultaneous push and pop: count is unchanged.
- INIT coinciding with a pop or capture: INIT wins, so the FIFO is empty and digest_valid=0 afterwards.

## Timing
- Reset value of every output is 0 (all readies, valids, responses, `rdata`, `core_*`).
- Reset asserted mid-transaction drops any pending `bvalid`/`rvalid` and flushes all state.
- Write accept:
  - Edge N samples `awvalid`&&`wvalid`&&!`bvalid`&&!`awready`, and, if the target is DATA, FIFO not full.
  - Then `awready`=`wready`=1 for exactly cycle N+1, and the register effect happens at edge N+1.
  - `bvalid`=1 from cycle N+2 and is held until the `bready` edge, then 0.
  - A DATA write to a full FIFO stalls, with no ready, until a pop frees space; it is never dropped.
- Read accept:
  - Edge N samples `arvalid`&&!`rvalid`&&!`arready`.
  - Then `arready`=1 for cycle N+1, and `rdata`/`rresp`/`rvalid` are registered at edge N+1.
  - These are held stable until the `rready` edge.
- STATUS reflects state registered before the read-accept edge.
- `core_in_*` is driven from FIFO head registers; the first word is visible 1 cycle after the push edge.
- `core_init` is high in the cycle following the CTRL write edge.

## Test plan
- Reset, then read STATUS → `rdata`=0x00000001, `rresp`=0, every output was 0 during reset.
- Hold `core_in_ready`=0 and write DATA 0x11,0x22,0x33,0x44 → STATUS=0x00000042; a fifth DATA write 0x55 gets no `awready` until `core_in_ready`=1 pops one word, then completes with `bresp`=0 and count=4.
- Write CTRL=0x0000000A, then DATA 0xDEADBEEF → the core sees `core_in_last`=1, `core_in_bytes`=2, STATUS bit3=1; a second DATA write has `core_in_last`=0.
- Pulse `core_out_valid` with digest {8{32'hA5A50000+i}} (word i) → STATUS bit2=1; nine DIGEST reads return words 0..7 and then word 0 again (wrap).
- DIGEST read before any digest → `rdata`=0, `rresp`=2'b10; write to STATUS → `bresp`=2'b10 with no state change.
- Fill the FIFO with 3 words and write CTRL=1 in the same cycle as a core pop → `core_init` is high for 1 cycle, then STATUS=0x00000001 and digest_valid=0.
